irq_ctrl: RTL and testbench
===========================

# irq_ctrl

Interrupt and fault request controller sitting directly upstream of the microcode decoder. It synchronises eight external interrupt lines and one MMU fault line, latches pending requests, applies a software mask, and drives the decoder's `irq_r` and `fault_r` inputs. It takes an entry acknowledge from the microcode interrupt-entry sequence and the decoder's `RETI` strobe, and it holds the cause code that the entry microcode reads.

## Interface
Parameters:
- `NIRQ`, 8, number of external interrupt lines; fixed at 8 in this revision because cause codes 0–7 map to lines.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `irq_lines`  in  NIRQ  asynchronous device interrupt lines; rising-edge sensitive.
- `fault_in`  in  1  synchronous MMU fault pulse, one cycle.
- `syscall`  in  1  decoder `SYSCALL` strobe.
- `reti`  in  1  decoder `RETI` strobe.
- `ack`  in  1  one-cycle pulse from the interrupt-entry microcode; consumes the current request.
- `mask_we`  in  1  mask write enable.
- `mask_wdata`  in  NIRQ  new mask; bit = 1 enables the corresponding line.
- `irq_r`  out  1  interrupt request to the decoder.
- `fault_r`  out  1  fault request to the decoder.
- `cause`  out  4  cause of the last taken event: 0–7 = line, 8 = fault, 9 = syscall, 15 = none.
- `pending`  out  NIRQ  latched pending bits, unmasked view.
- `mask`  out  NIRQ  current mask.
- `in_handler`  out  1  high between `ack` and `reti`.

## Operation
- Reset values:
  - `irq_r`, `fault_r`, `pending`, `mask`, `in_handler` = 0.
  - `cause` = 15.
  - FSM = IDLE.
  - Synchroniser and edge-detect flops = 0.
- Line path: each line goes through a 2-flop synchroniser, then a rising-edge detect. A detected edge sets `pending[i]`. Level-held lines do not retrigger.
- `fault_in` sets the internal fault latch directly, with no synchroniser.
- `syscall` sets the internal syscall latch.
- Priority: fault > syscall > lowest-numbered `pending & mask` bit.
- FSM states:
  - IDLE:
    - If the fault latch is set: `fault_r` = 1, go to REQ.
    - Else if `|(pending & mask)` or the syscall latch is set: `irq_r` = 1, go to REQ.
  - REQ: hold `irq_r`/`fault_r` until `ack`. On `ack`:
    - load `cause` with the highest-priority source;
    - clear that source (pending bit, fault latch, or syscall latch);
    - drop `irq_r`/`fault_r`;
    - set `in_handler`;
    - go to ACTIVE.
  - ACTIVE:
    - Interrupts and syscalls stay latched but are not requested.
    - A new fault raises `fault_r` and returns to REQ; faults nest.
    - `reti` clears `in_handler` and goes to IDLE.
- Priority is re-evaluated only in IDLE. The source encoded at `ack` is the one with highest priority in the ack cycle, even if it differs from the one that raised the request.
- `ack` outside REQ and `reti` outside ACTIVE are ignored.
- `mask` written on `mask_we` takes effect for the next evaluation. Masking the only pending source while in REQ does not withdraw the request; `ack` then yields `cause` = 15 and no bit is cleared.
- Simultaneous events:
  - An edge on line i in the same cycle that `ack` clears `pending[i]`: the set wins.
  - `fault_in` coincident with `ack`: the fault stays latched and is requested next cycle.

## Timing
- Line rising before edge N: `pending[i]` = 1 after edge N+2 (sync 2 + detect). `irq_r` = 1 after edge N+3 if unmasked and the FSM is IDLE.
- `fault_in` at edge N: `fault_r` = 1 after edge N+1 from IDLE or ACTIVE.
- `ack` at edge N: `irq_r`/`fault_r` = 0 and `cause` valid after edge N.
- All outputs are registered; no combinational input-to-output paths.
- `reset` assertion clears everything immediately, mid-request included. The first edge detect after release sees prior state 0, so a line already high at release produces one pending event.

## Structure
- Shared package `irq_pkg`:
  - cause codes: `CAUSE_FAULT` = 8, `CAUSE_SYSCALL` = 9, `CAUSE_NONE` = 15;
  - FSM encoding IDLE/REQ/ACTIVE;
  - `NIRQ`.
- Sub-module `irq_sync`: 2-flop synchroniser plus rising-edge detect, one instance per line.

## Test plan
- Line 3 pulses high, mask = 0xFF → `pending` = 0x08 after 3 edges, `irq_r` = 1 after 4. On `ack`: `cause` = 3, `pending` = 0, `in_handler` = 1.
- Lines 2 and 5 rise together, mask = 0xFB → first `ack` gives `cause` = 5. `pending[2]` stays 1 and no second request is made until `reti`.
- `fault_in` during ACTIVE → `fault_r` = 1 next edge. `ack` gives `cause` = 8. `reti` returns to IDLE.
- `syscall` and line 0 rise together → `ack` gives `cause` = 9. After `reti`, `irq_r` re-asserts and the next `ack` gives `cause` = 0.
- In REQ, `mask_we` with 0x00 → `irq_r` stays high. `ack` gives `cause` = 15, no pending bit cleared.
- `reset` asserted in REQ → all outputs at reset values immediately. A line held high through release yields exactly one pending set.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt/fault request controller.
package irq_pkg;

  localparam int unsigned NIRQ = 8;

  localparam logic [3:0] CAUSE_FAULT   = 4'd8;
  localparam logic [3:0] CAUSE_SYSCALL = 4'd9;
  localparam logic [3:0] CAUSE_NONE    = 4'd15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACTIVE = 2'd2
  } irq_state_e;

  // Cause code of the lowest-numbered set bit, CAUSE_NONE when empty.
  function automatic logic [3:0] lowest_line(input logic [NIRQ-1:0] req);
    logic found;
    lowest_line = CAUSE_NONE;
    found       = 1'b0;
    for (int unsigned i = 0; i < NIRQ; i++) begin
      if (req[i] && !found) begin
        lowest_line = 4'(i);
        found       = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/irq_ctrl_sync.sv
// Two-flop synchroniser followed by a rising-edge detector for one line.
module irq_sync (
  input  logic clk,
  input  logic reset,
  input  logic line,
  output logic rise
);

  logic meta;
  logic sync;
  logic prev;

  // Synchroniser chain plus the delayed copy used for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= line;
      sync <= meta;
      prev <= sync;
    end
  end

  // One-cycle strobe on each synchronised 0->1 transition.
  always_comb begin
    rise = sync & ~prev;
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt and fault request controller feeding the microcode decoder.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int unsigned NIRQ = irq_pkg::NIRQ
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NIRQ-1:0] irq_lines,
  input  logic            fault_in,
  input  logic            syscall,
  input  logic            reti,
  input  logic            ack,
  input  logic            mask_we,
  input  logic [NIRQ-1:0] mask_wdata,
  output logic            irq_r,
  output logic            fault_r,
  output logic [3:0]      cause,
  output logic [NIRQ-1:0] pending,
  output logic [NIRQ-1:0] mask,
  output logic            in_handler
);

  irq_state_e      state;
  irq_state_e      state_nx;
  logic [NIRQ-1:0] rise;
  logic            fault_lat;
  logic            sys_lat;

  logic            irq_nx;
  logic            fault_nx;
  logic [3:0]      cause_nx;
  logic            inh_nx;
  logic [NIRQ-1:0] clr_pend;
  logic            clr_fault;
  logic            clr_sys;
  logic [3:0]      sel;

  for (genvar g = 0; g < NIRQ; g++) begin : g_sync
    irq_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .line  (irq_lines[g]),
      .rise  (rise[g])
    );
  end

  // Request latches: a new event in the same cycle as its clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending   <= '0;
      fault_lat <= 1'b0;
      sys_lat   <= 1'b0;
      mask      <= '0;
    end else begin
      pending   <= (pending & ~clr_pend) | rise;
      fault_lat <= (fault_lat & ~clr_fault) | fault_in;
      sys_lat   <= (sys_lat & ~clr_sys) | syscall;
      if (mask_we) begin
        mask <= mask_wdata;
      end
    end
  end

  // FSM state and registered decoder-facing outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      irq_r      <= 1'b0;
      fault_r    <= 1'b0;
      cause      <= CAUSE_NONE;
      in_handler <= 1'b0;
    end else begin
      state      <= state_nx;
      irq_r      <= irq_nx;
      fault_r    <= fault_nx;
      cause      <= cause_nx;
      in_handler <= inh_nx;
    end
  end

  // Next-state, request generation and source selection at ack.
  always_comb begin
    state_nx  = state;
    irq_nx    = irq_r;
    fault_nx  = fault_r;
    cause_nx  = cause;
    inh_nx    = in_handler;
    clr_pend  = '0;
    clr_fault = 1'b0;
    clr_sys   = 1'b0;
    sel       = lowest_line(pending & mask);

    unique case (state)
      IDLE: begin
        if (fault_lat) begin
          fault_nx = 1'b1;
          state_nx = REQ;
        end else if ((|(pending & mask)) || sys_lat) begin
          irq_nx   = 1'b1;
          state_nx = REQ;
        end
      end

      REQ: begin
        if (ack) begin
          irq_nx   = 1'b0;
          fault_nx = 1'b0;
          inh_nx   = 1'b1;
          state_nx = ACTIVE;
          if (fault_lat) begin
            cause_nx  = CAUSE_FAULT;
            clr_fault = 1'b1;
          end else if (sys_lat) begin
            cause_nx = CAUSE_SYSCALL;
            clr_sys  = 1'b1;
          end else begin
            // sel is CAUSE_NONE when everything got masked; no bit matches it.
            cause_nx = sel;
            for (int unsigned i = 0; i < NIRQ; i++) begin
              clr_pend[i] = (sel == 4'(i));
            end
          end
        end
      end

      ACTIVE: begin
        // A fault arriving with reti is requested from IDLE on the next cycle.
        if (reti) begin
          inh_nx   = 1'b0;
          state_nx = IDLE;
        end else if (fault_lat) begin
          fault_nx = 1'b1;
          state_nx = REQ;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: ack responses checked by a separate monitor.
module tb_irq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irq_lines;
  logic       fault_in;
  logic       syscall;
  logic       reti;
  logic       ack;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic       irq_r;
  logic       fault_r;
  logic [3:0] cause;
  logic [7:0] pending;
  logic [7:0] mask;
  logic       in_handler;

  typedef struct {
    logic [3:0] cause;
    logic [7:0] pending;
    logic       in_h;
  } sb_t;

  sb_t sbq[$];

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model state: what the controller should have latched.
  logic [7:0] m_pending;
  logic [7:0] m_mask;
  logic       m_fault;
  logic       m_sys;

  irq_ctrl #(.NIRQ(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_lines  (irq_lines),
    .fault_in   (fault_in),
    .syscall    (syscall),
    .reti       (reti),
    .ack        (ack),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .irq_r      (irq_r),
    .fault_r    (fault_r),
    .cause      (cause),
    .pending    (pending),
    .mask       (mask),
    .in_handler (in_handler)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_mask(input logic [7:0] m);
    mask_we    = 1'b1;
    mask_wdata = m;
    tick();
    mask_we    = 1'b0;
    m_mask     = m;
  endtask

  // One-cycle pulse on the given lines, then wait until a request could show.
  task automatic raise_and_wait(input logic [7:0] p);
    irq_lines = p;
    tick();
    irq_lines = '0;
    repeat (3) tick();
    m_pending = m_pending | p;
  endtask

  // Expected response is computed from the priority rules and queued.
  task automatic do_ack(input bit with_fault, input logic [7:0] new_edges);
    sb_t         e;
    logic [7:0]  act;
    int unsigned c;
    act = m_pending & m_mask;
    if (m_fault) begin
      c       = 8;
      m_fault = 1'b0;
    end else if (m_sys) begin
      c     = 9;
      m_sys = 1'b0;
    end else begin
      c = 15;
      for (int i = 7; i >= 0; i--) begin
        if (act[i]) c = i;
      end
      if (c != 15) m_pending[c] = 1'b0;
    end
    m_pending = m_pending | new_edges;
    e.cause   = 4'(c);
    e.pending = m_pending;
    e.in_h    = 1'b1;
    sbq.push_back(e);
    ack      = 1'b1;
    fault_in = with_fault;
    tick();
    ack      = 1'b0;
    fault_in = 1'b0;
    if (with_fault) m_fault = 1'b1;
  endtask

  task automatic do_reti();
    reti = 1'b1;
    tick();
    reti = 1'b0;
    chk("reti_in_handler", 32'(in_handler), 32'd0);
  endtask

  // Monitor: each accepted ack is compared against the oldest queued expectation.
  initial begin
    sb_t e;
    forever begin
      @(posedge clk);
      if (ack === 1'b1) begin
        #2;
        if (sbq.size() == 0) begin
          chk("sb_unexpected_ack", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("ack_cause", 32'(cause), 32'(e.cause));
          chk("ack_pending", 32'(pending), 32'(e.pending));
          chk("ack_in_handler", 32'(in_handler), 32'(e.in_h));
          chk("ack_irq_r_drop", 32'(irq_r), 32'd0);
          chk("ack_fault_r_drop", 32'(fault_r), 32'd0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] p;
    logic [7:0] m;

    reset      = 1'b1;
    irq_lines  = '0;
    fault_in   = 1'b0;
    syscall    = 1'b0;
    reti       = 1'b0;
    ack        = 1'b0;
    mask_we    = 1'b0;
    mask_wdata = '0;
    m_pending  = '0;
    m_mask     = '0;
    m_fault    = 1'b0;
    m_sys      = 1'b0;
    repeat (3) tick();
    chk("rst_irq_r", 32'(irq_r), 32'd0);
    chk("rst_fault_r", 32'(fault_r), 32'd0);
    chk("rst_cause", 32'(cause), 32'd15);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_mask", 32'(mask), 32'd0);
    chk("rst_in_handler", 32'(in_handler), 32'd0);
    reset = 1'b0;
    tick();

    // Line 3 latency and basic ack.
    write_mask(8'hFF);
    chk("mask_write", 32'(mask), 32'hFF);
    irq_lines[3] = 1'b1;
    tick();
    irq_lines[3] = 1'b0;
    chk("l3_pend_e1", 32'(pending), 32'h00);
    tick();
    chk("l3_pend_e2", 32'(pending), 32'h00);
    tick();
    chk("l3_pend_e3", 32'(pending), 32'h08);
    chk("l3_irq_e3", 32'(irq_r), 32'd0);
    tick();
    chk("l3_irq_e4", 32'(irq_r), 32'd1);
    m_pending[3] = 1'b1;
    do_ack(1'b0, 8'h00);
    do_reti();

    // Lines 2 and 5 together with line 2 masked.
    write_mask(8'hFB);
    raise_and_wait(8'h24);
    chk("l25_irq", 32'(irq_r), 32'd1);
    do_ack(1'b0, 8'h00);
    tick();
    tick();
    chk("l25_no_req_active", 32'(irq_r), 32'd0);
    do_reti();
    tick();
    tick();
    chk("l25_masked_idle", 32'(irq_r), 32'd0);
    write_mask(8'hFF);
    tick();
    chk("l2_unmasked_req", 32'(irq_r), 32'd1);
    do_ack(1'b0, 8'h00);
    do_reti();

    // Fault nests inside an active handler.
    raise_and_wait(8'h02);
    do_ack(1'b0, 8'h00);
    fault_in = 1'b1;
    tick();
    fault_in = 1'b0;
    m_fault  = 1'b1;
    chk("flt_r_e0", 32'(fault_r), 32'd0);
    tick();
    chk("flt_r_e1", 32'(fault_r), 32'd1);
    do_ack(1'b0, 8'h00);
    do_reti();
    tick();
    tick();
    chk("flt_idle_quiet", 32'(irq_r | fault_r), 32'd0);

    // Syscall beats line 0; line 0 served after reti.
    syscall      = 1'b1;
    irq_lines[0] = 1'b1;
    tick();
    syscall      = 1'b0;
    irq_lines[0] = 1'b0;
    repeat (3) tick();
    m_sys        = 1'b1;
    m_pending[0] = 1'b1;
    chk("sys_irq", 32'(irq_r), 32'd1);
    do_ack(1'b0, 8'h00);
    do_reti();
    tick();
    chk("sys_l0_rereq", 32'(irq_r), 32'd1);
    do_ack(1'b0, 8'h00);
    do_reti();

    // Masking the only source while requesting does not withdraw it.
    raise_and_wait(8'h40);
    chk("mk_irq", 32'(irq_r), 32'd1);
    write_mask(8'h00);
    tick();
    chk("mk_irq_held", 32'(irq_r), 32'd1);
    do_ack(1'b0, 8'h00);
    do_reti();
    tick();
    tick();
    chk("mk_idle_quiet", 32'(irq_r), 32'd0);
    write_mask(8'hFF);
    tick();
    chk("mk_l6_req", 32'(irq_r), 32'd1);
    do_ack(1'b0, 8'h00);
    do_reti();

    // Edge on a line in the same cycle its pending bit is cleared.
    raise_and_wait(8'h08);
    chk("ea_irq", 32'(irq_r), 32'd1);
    irq_lines[3] = 1'b1;
    tick();
    irq_lines[3] = 1'b0;
    tick();
    do_ack(1'b0, 8'h08);
    do_reti();
    tick();
    chk("ea_rereq", 32'(irq_r), 32'd1);
    do_ack(1'b0, 8'h00);
    do_reti();

    // Fault coincident with ack stays latched and is requested next.
    raise_and_wait(8'h02);
    do_ack(1'b1, 8'h00);
    tick();
    chk("fa_fault_r", 32'(fault_r), 32'd1);
    do_ack(1'b0, 8'h00);
    do_reti();

    // Randomised line/mask patterns, drained one ack at a time.
    for (int it = 0; it < 6; it++) begin
      p = 8'($urandom_range(1, 255));
      m = 8'($urandom_range(0, 255));
      write_mask(m);
      raise_and_wait(p);
      tick();
      chk("rnd_req", 32'(irq_r), 32'((m_pending & m_mask) != 0));
      for (int k = 0; k < 9 && (m_pending & m_mask) != 0; k++) begin
        do_ack(1'b0, 8'h00);
        do_reti();
        tick();
        chk("rnd_rereq", 32'(irq_r), 32'((m_pending & m_mask) != 0));
      end
      chk("rnd_pending", 32'(pending), 32'(m_pending));
    end

    // Asynchronous reset mid-request; a held line yields one pending event.
    write_mask(8'hFF);
    raise_and_wait(8'h10);
    chk("rr_irq", 32'(irq_r), 32'd1);
    irq_lines[7] = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("rr_irq_r", 32'(irq_r), 32'd0);
    chk("rr_fault_r", 32'(fault_r), 32'd0);
    chk("rr_cause", 32'(cause), 32'd15);
    chk("rr_pending", 32'(pending), 32'd0);
    chk("rr_mask", 32'(mask), 32'd0);
    chk("rr_in_handler", 32'(in_handler), 32'd0);
    m_pending = '0;
    m_mask    = '0;
    m_fault   = 1'b0;
    m_sys     = 1'b0;
    tick();
    reset = 1'b0;
    repeat (5) tick();
    chk("rr_held_once", 32'(pending), 32'h80);
    m_pending[7] = 1'b1;
    write_mask(8'hFF);
    tick();
    chk("rr_l7_req", 32'(irq_r), 32'd1);
    do_ack(1'b0, 8'h00);
    repeat (4) tick();
    chk("rr_no_retrigger", 32'(pending), 32'h00);
    irq_lines[7] = 1'b0;
    do_reti();

    repeat (3) tick();
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
